// File: rtl/grf_scan.sv
// Sequential read-out engine for the GRF: walks both read ports two registers at a time
// and streams (index, value) words over valid/ready while folding an XOR checksum.
module grf_scan #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] RA,
  output logic [AW-1:0] RB,
  input  logic [DW-1:0] busA,
  input  logic [DW-1:0] busB,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  typedef enum logic [2:0] {IDLE, READ, SEND_A, SEND_B, DONE} state_t;

  localparam logic [AW-1:0] LAST_K = AW'(NREG - 2);

  state_t        state;
  logic [AW-1:0] k;
  logic [DW-1:0] holdA;
  logic [DW-1:0] holdB;

  // Both words of a pair are latched in READ, so a GRF write landing during the
  // SEND phases of that pair is deliberately not reflected in the streamed data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      RA        <= '0;
      RB        <= '0;
      holdA     <= '0;
      holdB     <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            RA       <= '0;
            RB       <= AW'(1);
            k        <= '0;
            checksum <= '0;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          holdA     <= busA;
          holdB     <= busB;
          out_valid <= 1'b1;
          out_idx   <= k;
          out_data  <= busA;
          state     <= SEND_A;
        end
        SEND_A: begin
          if (out_ready) begin
            checksum <= checksum ^ holdA;
            out_idx  <= k + AW'(1);
            out_data <= holdB;
            state    <= SEND_B;
          end
        end
        SEND_B: begin
          if (out_ready) begin
            checksum  <= checksum ^ holdB;
            out_valid <= 1'b0;
            if (k == LAST_K) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              k     <= k + AW'(2);
              RA    <= k + AW'(2);
              RB    <= k + AW'(3);
              state <= READ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
